relay_memory_responder: RTL and testbench
=========================================

RELAY_MEMORY_RESPONDER -- requirements
Module: relay_memory_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of byte locations, 1..65536.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, access wait states between accept and response, 0..15.
REQ-003 SHALL have parameter PROTECT_LIMIT, default 16'h0040, first writable address when write protection is compiled in.
REQ-004 SHALL have ports: clock  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have ports: resetN  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports: MemRead  input  1  read strobe from sequencer, level, held until response.
REQ-007 SHALL have ports: MemWrite  input  1  write strobe from sequencer, level, held until response.
REQ-008 SHALL have ports: Halt  input  1  sequencer halted; blocks new request acceptance.
REQ-009 SHALL have ports: addressBus  input  16  access address.
REQ-010 SHALL have ports: dataBus  input  8  write data.
REQ-011 SHALL have ports: readData  output  8  read result, valid with readValid.
REQ-012 SHALL have ports: readValid  output  1  one-cycle read completion pulse.
REQ-013 SHALL have ports: writeDone  output  1  one-cycle write completion pulse.
REQ-014 SHALL have ports: busy  output  1  high in every state except IDLE.
REQ-015 SHALL have ports: addrError  output  1  one-cycle pulse, address >= MEM_DEPTH.
REQ-016 SHALL have ports: conflictError  output  1  one-cycle pulse, both strobes high at accept.
REQ-017 SHALL have ports: writeProtErr  output  1  one-cycle pulse, protected write discarded.

Function
REQ-018 SHALL implement states IDLE, ACCESS, RESPOND, RELEASE.
REQ-019 IDLE: exactly one strobe high and Halt low -> latch address, data, direction; go ACCESS (WAIT_CYCLES>0) or RESPOND (WAIT_CYCLES=0).
REQ-020 IDLE, both strobes high, Halt low: no memory access; conflictError pulses next cycle; go RELEASE.
REQ-021 IDLE, Halt high: stay IDLE regardless of strobes; Halt during ACCESS/RESPOND does not abort the access.
REQ-022 ACCESS: 4-bit counter loaded with WAIT_CYCLES-1, decrements each cycle; at zero go RESPOND.
REQ-023 Accept-to-pulse latency SHALL be exactly WAIT_CYCLES+1 cycles.
REQ-024 RESPOND read: readData = mem[latched address], readValid high one cycle; readData holds until next read response or reset.
REQ-025 RESPOND write: mem[latched address] <= latched data on RESPOND entry edge; writeDone high one cycle.
REQ-026 Latched address >= MEM_DEPTH: read returns 8'hFF with readValid; write discarded with writeDone; addrError pulses with it.
REQ-027 RESPOND always -> RELEASE; RELEASE -> IDLE only when MemRead and MemWrite both low (same request never serviced twice).
REQ-028 Address/data changes after accept SHALL be ignored.

Reset
REQ-029 resetN low SHALL force IDLE, counter 0, readData 8'h00, all pulses and busy 0, immediately and asynchronously.
REQ-030 Reset mid-access SHALL abandon the access without writing; memory contents SHALL NOT be cleared by reset.

Configuration
REQ-031 Macro RELAY_MEM_WRITE_PROTECT_EN defined: in-range writes with address < PROTECT_LIMIT discarded, writeDone and writeProtErr pulse together; reads unaffected.
REQ-032 Macro undefined: all in-range writes performed; writeProtErr port present, tied 0.

Verification
REQ-033 WAIT_CYCLES=2: write 8'h5A to 16'h0080, then read 16'h0080 -> writeDone 3 cycles after accept; readData 8'h5A, readValid 3 cycles after accept.
REQ-034 Read 16'h0100 with MEM_DEPTH=256 -> readData 8'hFF, readValid and addrError same cycle.
REQ-035 MemRead and MemWrite both high in IDLE -> conflictError one cycle, no readValid/writeDone, busy until both low.
REQ-036 MemRead held 10 cycles -> exactly one readValid; busy stays high until MemRead drops.
REQ-037 resetN low in ACCESS of write 8'h33 to 16'h0090 -> outputs zero, later read of 16'h0090 returns prior content; Halt high in IDLE with MemRead -> busy stays 0.
REQ-038 With RELAY_MEM_WRITE_PROTECT_EN: write 8'hAA to 16'h0010 -> writeDone+writeProtErr, read returns old value; without: read returns 8'hAA.

Source files
------------

// File: rtl/relay_memory_responder.sv
// relay_memory_responder: byte memory slave for a relay sequencer.
// Accepts one level-held read or write strobe, waits WAIT_CYCLES, answers
// with a one-cycle completion pulse, then holds in RELEASE until both
// strobes drop so that a held request is never serviced twice.
// Optional feature macro: RELAY_MEM_WRITE_PROTECT_EN (writes below
// PROTECT_LIMIT are discarded and flagged on writeProtErr).
module relay_memory_responder #(
  parameter int          MEM_DEPTH     = 256,
  parameter int          WAIT_CYCLES   = 2,
  parameter logic [15:0] PROTECT_LIMIT = 16'h0040
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Halt,
  input  logic [15:0] addressBus,
  input  logic [7:0]  dataBus,
  output logic [7:0]  readData,
  output logic        readValid,
  output logic        writeDone,
  output logic        busy,
  output logic        addrError,
  output logic        conflictError,
  output logic        writeProtErr
);

  localparam int          AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [16:0] DEPTH17  = 17'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND, RELEASE} state_t;

  state_t      state, next_state;
  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic        dir_wr_q;
  logic [3:0]  cnt;
  logic [7:0]  mem [MEM_DEPTH];

  logic        accept, conflict;
  logic        entering;
  logic [15:0] ent_addr;
  logic [7:0]  ent_data;
  logic        ent_wr;
  logic        ent_in_range, q_in_range;
  logic        ent_prot, q_prot;
  logic        mem_we;
  logic [7:0]  rd_val;
  logic        rv_d, wd_d, ae_d, ce_d, pe_d;

  assign accept   = (state == IDLE) && !Halt && (MemRead ^ MemWrite);
  assign conflict = (state == IDLE) && !Halt && MemRead && MemWrite;

  // The memory write happens on the edge that enters RESPOND; with no wait
  // states that is the accept edge itself, so the live bus is used then.
  assign entering = (next_state == RESPOND) && (state != RESPOND);
  assign ent_addr = (state == IDLE) ? addressBus : addr_q;
  assign ent_data = (state == IDLE) ? dataBus    : data_q;
  assign ent_wr   = (state == IDLE) ? MemWrite   : dir_wr_q;

  assign ent_in_range = {1'b0, ent_addr} < DEPTH17;
  assign q_in_range   = {1'b0, addr_q}   < DEPTH17;

`ifdef RELAY_MEM_WRITE_PROTECT_EN
  assign ent_prot = ent_addr < PROTECT_LIMIT;
  assign q_prot   = addr_q   < PROTECT_LIMIT;
`else
  assign ent_prot = 1'b0;
  assign q_prot   = 1'b0;
`endif

  // resetN gating keeps an access that is being abandoned from writing.
  assign mem_we = resetN && entering && ent_wr && ent_in_range && !ent_prot;
  assign rd_val = q_in_range ? mem[addr_q[AW-1:0]] : 8'hFF;

  // State register.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (conflict)    next_state = RELEASE;
        else if (accept) next_state = (WAIT_CYCLES > 0) ? ACCESS : RESPOND;
      end
      ACCESS:  if (cnt == 4'd0) next_state = RESPOND;
      RESPOND: next_state = RELEASE;
      RELEASE: if (!MemRead && !MemWrite) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: completion flags are computed in RESPOND and registered,
  // giving an accept-to-pulse latency of WAIT_CYCLES+1.
  always_comb begin
    rv_d = 1'b0;
    wd_d = 1'b0;
    ae_d = 1'b0;
    pe_d = 1'b0;
    ce_d = conflict;
    busy = (state != IDLE);
    if (state == RESPOND) begin
      ae_d = !q_in_range;
      if (dir_wr_q) begin
        wd_d = 1'b1;
        pe_d = q_in_range && q_prot;
      end else begin
        rv_d = 1'b1;
      end
    end
  end

  // Registered completion pulses and read data (readData holds between reads).
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      readData      <= 8'h00;
      readValid     <= 1'b0;
      writeDone     <= 1'b0;
      addrError     <= 1'b0;
      conflictError <= 1'b0;
      writeProtErr  <= 1'b0;
    end else begin
      readValid     <= rv_d;
      writeDone     <= wd_d;
      addrError     <= ae_d;
      conflictError <= ce_d;
      writeProtErr  <= pe_d;
      if (rv_d) readData <= rd_val;
    end
  end

  // Request capture on accept; later bus changes are ignored.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      addr_q   <= 16'h0000;
      data_q   <= 8'h00;
      dir_wr_q <= 1'b0;
    end else if (accept) begin
      addr_q   <= addressBus;
      data_q   <= dataBus;
      dir_wr_q <= MemWrite;
    end
  end

  // Wait-state counter: loaded on accept, counts down through ACCESS.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)                             cnt <= 4'd0;
    else if (accept)                         cnt <= CNT_INIT;
    else if (state == ACCESS && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  // Storage array; deliberately not cleared by reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[ent_addr[AW-1:0]] <= ent_data;
  end

endmodule

// File: tb/tb_relay_memory_responder.sv
// Directed bench for relay_memory_responder (default parameters:
// MEM_DEPTH=256, WAIT_CYCLES=2, so every response lands 3 cycles after accept).
module tb_relay_memory_responder;

  logic        clock = 1'b0;
  logic        resetN;
  logic        MemRead, MemWrite, Halt;
  logic [15:0] addressBus;
  logic [7:0]  dataBus;
  logic [7:0]  readData;
  logic        readValid, writeDone, busy, addrError, conflictError, writeProtErr;

  int checks   = 0;
  int failures = 0;

  relay_memory_responder dut (
    .clock(clock), .resetN(resetN), .MemRead(MemRead), .MemWrite(MemWrite),
    .Halt(Halt), .addressBus(addressBus), .dataBus(dataBus),
    .readData(readData), .readValid(readValid), .writeDone(writeDone),
    .busy(busy), .addrError(addrError), .conflictError(conflictError),
    .writeProtErr(writeProtErr)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one request, hold the strobe 8 cycles past accept, then drop it.
  task automatic run_req(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [7:0] d, input bit scramble,
                         output int lat, output int npulse, output logic [7:0] rdat,
                         output logic ae, output logic pe, output logic busy_ok,
                         output logic idle_ok);
    MemRead = rd; MemWrite = wr; addressBus = a; dataBus = d;
    step();
    busy_ok = busy;
    if (scramble) begin
      addressBus = a ^ 16'h0003;
      dataBus    = ~d;
    end
    lat = -1; npulse = 0; rdat = 8'h00; ae = 1'b0; pe = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      busy_ok = busy_ok & busy;
      if (readValid || writeDone) begin
        npulse++;
        if (lat < 0) begin
          lat = k; rdat = readData; ae = addrError; pe = writeProtErr;
        end
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    step();
    idle_ok = !busy;
  endtask

  task automatic test_reset();
    resetN = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Halt = 1'b0;
    addressBus = 16'h0000; dataBus = 8'h00;
    #3;
    checks++; if (readData !== 8'h00) begin failures++; $display("FAIL reset_readData got=%h exp=00", readData); end
    checks++; if ({readValid, writeDone, busy, addrError, conflictError, writeProtErr} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=000000",
        {readValid, writeDone, busy, addrError, conflictError, writeProtErr}); end
    step(); step();
    resetN = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_write_read();
    int lat, np; logic [7:0] rd; logic ae, pe, bo, io;
    run_req(1'b0, 1'b1, 16'h0080, 8'h5A, 1'b0, lat, np, rd, ae, pe, bo, io);
    checks++; if (lat !== 3 || np !== 1) begin failures++; $display("FAIL wr_latency got lat=%0d n=%0d exp lat=3 n=1", lat, np); end
    checks++; if (ae !== 1'b0 || pe !== 1'b0) begin failures++; $display("FAIL wr_flags got ae=%b pe=%b exp 0 0", ae, pe); end
    checks++; if (bo !== 1'b1 || io !== 1'b1) begin failures++; $display("FAIL wr_busy got held=%b idle=%b exp 1 1", bo, io); end
    run_req(1'b1, 1'b0, 16'h0080, 8'h00, 1'b0, lat, np, rd, ae, pe, bo, io);
    checks++; if (lat !== 3 || np !== 1) begin failures++; $display("FAIL rd_latency got lat=%0d n=%0d exp lat=3 n=1", lat, np); end
    checks++; if (rd !== 8'h5A) begin failures++; $display("FAIL rd_data got=%h exp=5a", rd); end
    // readData must hold across a following write
    run_req(1'b0, 1'b1, 16'h0081, 8'hC3, 1'b0, lat, np, rd, ae, pe, bo, io);
    checks++; if (readData !== 8'h5A) begin failures++; $display("FAIL rd_hold got=%h exp=5a", readData); end
  endtask

  task automatic test_addr_error();
    int lat, np; logic [7:0] rd; logic ae, pe, bo, io;
    run_req(1'b1, 1'b0, 16'h0100, 8'h00, 1'b0, lat, np, rd, ae, pe, bo, io);
    checks++; if (lat !== 3 || rd !== 8'hFF || ae !== 1'b1) begin
      failures++; $display("FAIL oob_read got lat=%0d data=%h ae=%b exp 3 ff 1", lat, rd, ae); end
    run_req(1'b0, 1'b1, 16'hFFFF, 8'h12, 1'b0, lat, np, rd, ae, pe, bo, io);
    checks++; if (lat !== 3 || ae !== 1'b1 || pe !== 1'b0) begin
      failures++; $display("FAIL oob_write got lat=%0d ae=%b pe=%b exp 3 1 0", lat, ae, pe); end
    run_req(1'b1, 1'b0, 16'h00FF, 8'h00, 1'b0, lat, np, rd, ae, pe, bo, io);
    checks++; if (lat !== 3 || ae !== 1'b0) begin
      failures++; $display("FAIL last_addr got lat=%0d ae=%b exp 3 0", lat, ae); end
  endtask

  task automatic test_conflict();
    int nce, npulse; logic bo;
    int lat, np; logic [7:0] rd; logic ae, pe, bo2, io;
    MemRead = 1'b1; MemWrite = 1'b1; addressBus = 16'h0080; dataBus = 8'hEE;
    step();
    checks++; if (conflictError !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL conflict_pulse got ce=%b busy=%b exp 1 1", conflictError, busy); end
    nce = 0; npulse = 0; bo = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (conflictError) nce++;
      if (readValid || writeDone) npulse++;
      bo = bo & busy;
    end
    checks++; if (nce !== 0 || npulse !== 0 || bo !== 1'b1) begin
      failures++; $display("FAIL conflict_hold got ce=%0d pulses=%0d busy=%b exp 0 0 1", nce, npulse, bo); end
    MemRead = 1'b0; MemWrite = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL conflict_release got busy=%b exp 0", busy); end
    run_req(1'b1, 1'b0, 16'h0080, 8'h00, 1'b0, lat, np, rd, ae, pe, bo2, io);
    checks++; if (rd !== 8'h5A) begin failures++; $display("FAIL conflict_nowrite got=%h exp=5a", rd); end
  endtask

  task automatic test_hold();
    int nrv; logic bo;
    MemRead = 1'b1; addressBus = 16'h0080;
    nrv = 0; bo = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (readValid) nrv++;
      bo = bo & busy;
    end
    checks++; if (nrv !== 1 || bo !== 1'b1) begin
      failures++; $display("FAIL hold_once got rv=%0d busy=%b exp 1 1", nrv, bo); end
    MemRead = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_release got busy=%b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat, np; logic [7:0] rd; logic ae, pe, bo, io;
    run_req(1'b0, 1'b1, 16'h0090, 8'h11, 1'b0, lat, np, rd, ae, pe, bo, io);
    MemWrite = 1'b1; addressBus = 16'h0090; dataBus = 8'h33;
    step();
    resetN = 1'b0;
    #1;
    checks++; if ({readValid, writeDone, busy, addrError, conflictError, writeProtErr} !== 6'b0 || readData !== 8'h00) begin
      failures++; $display("FAIL midreset_outputs got flags=%b data=%h exp 000000 00",
        {readValid, writeDone, busy, addrError, conflictError, writeProtErr}, readData); end
    MemWrite = 1'b0;
    step(); step(); step();
    resetN = 1'b1;
    step();
    run_req(1'b1, 1'b0, 16'h0090, 8'h00, 1'b0, lat, np, rd, ae, pe, bo, io);
    checks++; if (rd !== 8'h11) begin failures++; $display("FAIL midreset_mem got=%h exp=11", rd); end
  endtask

  task automatic test_halt();
    int nrv, lat; logic bo;
    Halt = 1'b1; MemRead = 1'b1; addressBus = 16'h0080;
    nrv = 0; bo = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (readValid) nrv++;
      bo = bo | busy;
    end
    checks++; if (nrv !== 0 || bo !== 1'b0) begin
      failures++; $display("FAIL halt_idle got rv=%0d busy=%b exp 0 0", nrv, bo); end
    Halt = 1'b0;
    step();
    Halt = 1'b1;
    nrv = 0; lat = -1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (readValid) begin nrv++; if (lat < 0) lat = k; end
    end
    checks++; if (nrv !== 1 || lat !== 3) begin
      failures++; $display("FAIL halt_mid got rv=%0d lat=%0d exp 1 3", nrv, lat); end
    MemRead = 1'b0; Halt = 1'b0;
    step();
  endtask

  task automatic test_data_change();
    int lat, np; logic [7:0] rd; logic ae, pe, bo, io;
    run_req(1'b0, 1'b1, 16'h0084, 8'h3C, 1'b1, lat, np, rd, ae, pe, bo, io);
    run_req(1'b1, 1'b0, 16'h0084, 8'h00, 1'b0, lat, np, rd, ae, pe, bo, io);
    checks++; if (rd !== 8'h3C) begin failures++; $display("FAIL late_change got=%h exp=3c", rd); end
  endtask

  task automatic test_back_to_back();
    int lat, np; logic [7:0] rd; logic ae, pe, bo, io;
    run_req(1'b0, 1'b1, 16'h0020 + 16'h0060, 8'h77, 1'b0, lat, np, rd, ae, pe, bo, io);
    run_req(1'b0, 1'b1, 16'h0081 + 16'h0005, 8'h88, 1'b0, lat, np, rd, ae, pe, bo, io);
    run_req(1'b1, 1'b0, 16'h0080, 8'h00, 1'b0, lat, np, rd, ae, pe, bo, io);
    checks++; if (rd !== 8'h77) begin failures++; $display("FAIL b2b_first got=%h exp=77", rd); end
    run_req(1'b1, 1'b0, 16'h0086, 8'h00, 1'b0, lat, np, rd, ae, pe, bo, io);
    checks++; if (rd !== 8'h88) begin failures++; $display("FAIL b2b_second got=%h exp=88", rd); end
  endtask

  task automatic test_protect();
    int lat, np; logic [7:0] rd, old; logic ae, pe, bo, io;
    run_req(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, lat, np, old, ae, pe, bo, io);
    run_req(1'b0, 1'b1, 16'h0010, 8'hAA, 1'b0, lat, np, rd, ae, pe, bo, io);
`ifdef RELAY_MEM_WRITE_PROTECT_EN
    checks++; if (lat !== 3 || pe !== 1'b1 || ae !== 1'b0) begin
      failures++; $display("FAIL prot_flag got lat=%0d pe=%b ae=%b exp 3 1 0", lat, pe, ae); end
    run_req(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, lat, np, rd, ae, pe, bo, io);
    checks++; if (rd !== old) begin failures++; $display("FAIL prot_keep got=%h exp=%h", rd, old); end
`else
    checks++; if (lat !== 3 || pe !== 1'b0) begin
      failures++; $display("FAIL noprot_flag got lat=%0d pe=%b exp 3 0", lat, pe); end
    run_req(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, lat, np, rd, ae, pe, bo, io);
    checks++; if (rd !== 8'hAA) begin failures++; $display("FAIL noprot_write got=%h exp=aa", rd); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_addr_error();
    test_conflict();
    test_hold();
    test_reset_mid();
    test_halt();
    test_data_change();
    test_back_to_back();
    test_protect();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
